// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM bundle in, MEM/WB register out, load/store over a valid/ready data bus.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_rd,
  output logic        wb_misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Bundle fields kept across the WAIT phase for building the MEM/WB entry.
  typedef struct packed {
    logic [31:0] alu;
    logic [2:0]  funct3;
    logic        load;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } req_t;

  state_t      state, state_n;
  req_t        req_q;
  logic        is_mem, trap;
  logic        accept_mem, pass, complete;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                    ((funct3 == 3'b010) & (alu_result[1:0] != 2'b00));
  assign trap     = is_mem & misalign;
`else
  assign trap     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    mem_stall  = 1'b0;
    dmem_req   = 1'b0;
    accept_mem = 1'b0;
    pass       = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (is_mem && !trap) begin
            accept_mem = 1'b1;
            mem_stall  = 1'b1;
            state_n    = S_WAIT;
          end else begin
            pass = 1'b1;
          end
        end
      end
      S_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = !dmem_ready;
        if (dmem_ready) begin
          complete = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Store lanes are replicated so the strobe alone selects the target bytes.
  always_comb begin
    st_wdata = rs2_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_data[7:0]}};
        st_wstrb = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_data[15:0]}};
        st_wstrb = 4'b0011 << {alu_result[1], 1'b0};
      end
      default: begin
        st_wdata = rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (req_q.alu[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = req_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (req_q.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_wstrb    <= 4'h0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= 32'h0;
      wb_mem_data   <= 32'h0;
      wb_rd         <= 5'h0;
    end else begin
      if (accept_mem) begin
        req_q <= '{alu: alu_result, funct3: funct3, load: mem_read, rd: rd,
                   reg_write: reg_write, mem_to_reg: mem_to_reg};
        // read+write together is a load: no strobes, no write enable
        dmem_we    <= mem_write & !mem_read;
        dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem_wdata <= st_wdata;
        dmem_wstrb <= mem_read ? 4'h0 : st_wstrb;
      end
      if (pass) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= reg_write & !trap;
        wb_mem_to_reg <= mem_to_reg;
        wb_alu_result <= alu_result;
        wb_mem_data   <= 32'h0;
        wb_rd         <= rd;
      end else if (complete) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= req_q.reg_write;
        wb_mem_to_reg <= req_q.mem_to_reg;
        wb_alu_result <= req_q.alu;
        wb_mem_data   <= req_q.load ? ld_data : 32'h0;
        wb_rd         <= req_q.rd;
      end else begin
        wb_valid      <= 1'b0;
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_alu_result <= 32'h0;
        wb_mem_data   <= 32'h0;
        wb_rd         <= 5'h0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) wb_misalign <= 1'b0;
    else     wb_misalign <= pass & trap;
  end
`else
  assign wb_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset state, ALU pass-through, loads, stores, reset mid-access, misalignment.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, mem_read, mem_write, reg_write, mem_to_reg;
  logic [31:0] alu_result, rs2_data, dmem_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        dmem_ready;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_misalign;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [4:0]  wb_rd;

  int n_assert = 0;
  int n_fail   = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result), .rs2_data(rs2_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .rd(rd),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_rd(wb_rd),
    .wb_misalign(wb_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // Load with ready already high in IDLE (must be ignored) and in the first WAIT cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic both, input logic [31:0] rdata, input logic [31:0] exp);
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = both; funct3 = f3; alu_result = addr;
    rs2_data = 32'hFFFF_FFFF; rd = 5'd9; reg_write = 1'b1; mem_to_reg = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = rdata;
    #1;
    check({tag, " idle stall"}, mem_stall, 1);
    check({tag, " idle req"}, dmem_req, 0);
    step();
    check({tag, " wait req"}, dmem_req, 1);
    check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, " we"}, dmem_we, 0);
    check({tag, " wstrb"}, dmem_wstrb, 0);
    check({tag, " stall"}, mem_stall, 0);
    check({tag, " bubble"}, wb_valid, 0);
    step();
    idle_inputs();
    check({tag, " wb_valid"}, wb_valid, 1);
    check({tag, " wb_mem_data"}, wb_mem_data, exp);
    check({tag, " wb_alu"}, wb_alu_result, addr);
    check({tag, " wb_rd"}, wb_rd, 9);
    check({tag, " wb_m2r"}, wb_mem_to_reg, 1);
  endtask

  // Store with one WAIT cycle of back-pressure before ready.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs2, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = f3; alu_result = addr;
    rs2_data = rs2; rd = 5'd0; reg_write = 1'b0; mem_to_reg = 1'b0; dmem_ready = 1'b0;
    step();
    check({tag, " req"}, dmem_req, 1);
    check({tag, " we"}, dmem_we, 1);
    check({tag, " addr"}, dmem_addr, exp_addr);
    check({tag, " wdata"}, dmem_wdata, exp_wdata);
    check({tag, " wstrb"}, dmem_wstrb, exp_wstrb);
    check({tag, " stall"}, mem_stall, 1);
    dmem_ready = 1'b1;
    #1;
    check({tag, " ready stall"}, mem_stall, 0);
    step();
    idle_inputs();
    check({tag, " wb_valid"}, wb_valid, 1);
    check({tag, " wb_mem_data"}, wb_mem_data, 0);
    check({tag, " wb_reg_write"}, wb_reg_write, 0);
  endtask

  initial begin
    idle_inputs();
    alu_result = 32'h0; rs2_data = 32'h0; funct3 = 3'b0; rd = 5'h0; dmem_rdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    check("rst wb_valid", wb_valid, 0);
    check("rst wb_reg_write", wb_reg_write, 0);
    check("rst wb_mem_to_reg", wb_mem_to_reg, 0);
    check("rst wb_alu_result", wb_alu_result, 0);
    check("rst wb_mem_data", wb_mem_data, 0);
    check("rst wb_rd", wb_rd, 0);
    check("rst wb_misalign", wb_misalign, 0);
    check("rst dmem_req", dmem_req, 0);
    check("rst dmem_we", dmem_we, 0);
    check("rst dmem_addr", dmem_addr, 0);
    check("rst dmem_wdata", dmem_wdata, 0);
    check("rst dmem_wstrb", dmem_wstrb, 0);
    check("rst mem_stall", mem_stall, 0);
    rst = 1'b0;

    // ADD: plain pass-through, one-cycle latency
    ex_valid = 1'b1; alu_result = 32'hAAAA_AAAA; reg_write = 1'b1; mem_to_reg = 1'b0; rd = 5'd5;
    #1;
    check("add stall", mem_stall, 0);
    check("add req", dmem_req, 0);
    step();
    idle_inputs();
    check("add wb_valid", wb_valid, 1);
    check("add wb_alu", wb_alu_result, 32'hAAAA_AAAA);
    check("add wb_mem_data", wb_mem_data, 0);
    check("add wb_rd", wb_rd, 5);
    check("add wb_reg_write", wb_reg_write, 1);
    check("add req after", dmem_req, 0);
    step();
    check("bubble wb_valid", wb_valid, 0);

    // LB at 0x103, ready in the fourth WAIT cycle
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b000; alu_result = 32'h0000_0103;
    rd = 5'd7; reg_write = 1'b1; mem_to_reg = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    stalls = 0;
    #1; stalls += int'(mem_stall);
    step(); stalls += int'(mem_stall);
    check("lb req", dmem_req, 1);
    check("lb addr", dmem_addr, 32'h0000_0100);
    check("lb bubble", wb_valid, 0);
    step(); stalls += int'(mem_stall);
    step(); stalls += int'(mem_stall);
    step();
    dmem_ready = 1'b1;
    #1; stalls += int'(mem_stall);
    check("lb stall cycles", stalls, 4);
    step();
    idle_inputs();
    check("lb wb_valid", wb_valid, 1);
    check("lb wb_mem_data", wb_mem_data, 32'hFFFF_FFDE);
    check("lb wb_m2r", wb_mem_to_reg, 1);
    check("lb wb_rd", wb_rd, 7);
    check("lb req dropped", dmem_req, 0);

    do_load("lhu", 32'h0000_0102, 3'b101, 1'b0, 32'hDEAD_BEEF, 32'h0000_DEAD);
    do_load("lbu", 32'h0000_0101, 3'b100, 1'b0, 32'hDEAD_BEEF, 32'h0000_00BE);
    do_load("lh",  32'h0000_0100, 3'b001, 1'b0, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lw rw", 32'h0000_0004, 3'b010, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);

    do_store("sb", 32'h0000_0201, 3'b000, 32'h1234_5678, 32'h0000_0200, 32'h7878_7878, 4'b0010);
    do_store("sh", 32'h0000_0202, 3'b001, 32'hABCD_1234, 32'h0000_0200, 32'h1234_1234, 4'b1100);

    // LW abandoned by reset in its second WAIT cycle
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0400;
    rd = 5'd3; reg_write = 1'b1; mem_to_reg = 1'b1;
    step();
    check("lw rst wait1 req", dmem_req, 1);
    step();
    rst = 1'b1;
    ex_valid = 1'b0;
    step();
    rst = 1'b0;
    idle_inputs();
    check("lw rst req", dmem_req, 0);
    check("lw rst addr", dmem_addr, 0);
    check("lw rst wb_valid", wb_valid, 0);
    check("lw rst wb_alu", wb_alu_result, 0);
    check("lw rst wb_rd", wb_rd, 0);
    check("lw rst stall", mem_stall, 0);
    ex_valid = 1'b1; alu_result = 32'h0000_0055; reg_write = 1'b1; rd = 5'd1;
    step();
    idle_inputs();
    check("post rst add valid", wb_valid, 1);
    check("post rst add alu", wb_alu_result, 32'h0000_0055);

    // SW at 0x302
`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0302;
    rs2_data = 32'h0BAD_F00D; rd = 5'd4; reg_write = 1'b1;
    #1;
    check("sw mis stall", mem_stall, 0);
    check("sw mis req", dmem_req, 0);
    step();
    idle_inputs();
    check("sw mis req after", dmem_req, 0);
    check("sw mis flag", wb_misalign, 1);
    check("sw mis reg_write", wb_reg_write, 0);
    check("sw mis valid", wb_valid, 1);
`else
    do_store("sw", 32'h0000_0302, 3'b010, 32'h0BAD_F00D, 32'h0000_0300, 32'h0BAD_F00D, 4'b1111);
    check("sw misalign tied", wb_misalign, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, feeding the write-back stage. Takes the EX/MEM bundle, runs loads and stores against the data memory over a valid/ready handshake, and formats load data with byte/halfword alignment and sign extension. Holds the MEM/WB pipeline register whose outputs drive the write-back mux: ALU result, memory data, and mem_to_reg select. Stalls upstream while a memory access is outstanding.

## Interface
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM bundle valid
- alu_result  in  32  ALU result; effective address for memory ops
- rs2_data  in  32  store data
- mem_read / mem_write  in  1 each  load / store
- funct3  in  3  access size and sign
- rd  in  5  destination register
- reg_write, mem_to_reg  in  1 each  passed to WB
- mem_stall  out  1  upstream must hold the EX/MEM bundle stable
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables; 0 on loads
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  raw load word, valid when dmem_ready=1
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB register
- wb_alu_result, wb_mem_data  out  32 each  MEM/WB register
- wb_rd  out  5  MEM/WB register
- wb_misalign  out  1  misaligned-access flag; tied 0 without MEM_MISALIGN_TRAP_EN

## Operation
- The FSM has two states: IDLE and WAIT.
- In IDLE with `ex_valid`=1 and no memory op:
  - The MEM/WB register loads the bundle at the next edge.
  - `wb_mem_data`=0 and `wb_valid`=1.
- In IDLE with `ex_valid`=1 and a memory op:
  - `mem_stall`=1.
  - Latch `dmem_addr`={alu_result[31:2],2'b00}, byte offset alu_result[1:0], funct3, wdata and wstrb.
  - Go to WAIT.
  - MEM/WB loads a bubble: `wb_valid`=0, `wb_reg_write`=0.
- In WAIT:
  - `dmem_req`=1 and the latched request is held stable.
  - `mem_stall`=!dmem_ready.
  - On `dmem_ready`=1: MEM/WB loads the bundle with formatted rdata, then go to IDLE.
- `mem_read`=`mem_write`=1 is treated as a load.
- Load format (offset o):
  - funct3 000 (LB): sign-extend byte o.
  - funct3 100 (LBU): zero-extend byte o.
  - funct3 001 (LH): sign-extend halfword o[1].
  - funct3 101 (LHU): zero-extend halfword o[1].
  - funct3 010 and reserved codes: full word.
- Store format:
  - SB: wdata = 4× rs2[7:0]; wstrb = 4'b0001<<o.
  - SH: wdata = 2× rs2[15:0]; wstrb = 4'b0011<<{o[1],1'b0}.
  - SW: wdata = rs2; wstrb = 4'b1111.
- Stores write `wb_mem_data`=0. `wb_reg_write` is passed through unchanged.

## Timing
- Reset values:
  - FSM in IDLE.
  - All `wb_*` outputs 0.
  - `dmem_req`=0, `dmem_we`=0, `dmem_wstrb`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `mem_stall`=0.
- Non-memory op: `wb_*` valid 1 cycle after the accept edge.
- Memory op: `wb_*` valid 1 cycle after the edge on which `dmem_ready`=1. Minimum 2 cycles from accept, with ready in the first WAIT cycle.
- `dmem_ready` is ignored in IDLE.
- `ex_valid`=0 in IDLE loads a bubble (`wb_valid`=0).
- Reset during WAIT:
  - Returns to IDLE and drops `dmem_req` at that edge.
  - The in-flight access is abandoned; memory must tolerate this.
- `mem_stall` is combinational from state, the ex inputs and `dmem_ready`.

## Configuration
- Macro: MEM_MISALIGN_TRAP_EN.
- Misaligned means LH/LHU/SH with o[0]=1, or LW/SW with o≠0.
- Defined:
  - A misaligned op issues no bus request and stays in IDLE.
  - MEM/WB loads at the next edge with `wb_misalign`=1, `wb_reg_write`=0, `wb_valid`=1.
- Undefined:
  - Misaligned low offset bits are ignored per size: LH/SH use o[1] only; LW/SW use the word address.
  - The access proceeds normally.
  - `wb_misalign` is tied to 0.

## Test plan
- ADD: alu_result=0xAAAAAAAA, mem_to_reg=0, no memory op -> next cycle `wb_valid`=1, `wb_alu_result`=0xAAAAAAAA, `wb_mem_data`=0, no `dmem_req`.
- LB, addr 0x103, memory returns 0xDEADBEEF with ready after 3 WAIT cycles -> `mem_stall` high for 4 cycles, `dmem_addr`=0x100, `wb_mem_data`=0xFFFFFFDE, `wb_mem_to_reg`=1.
- LHU, addr 0x102, rdata 0xDEADBEEF, ready immediately -> `wb_mem_data`=0x0000DEAD, 2-cycle latency.
- SB, addr 0x201, rs2=0x12345678 -> `dmem_wdata`=0x78787878, `dmem_wstrb`=0010, `dmem_we`=1; then `wb_mem_data`=0.
- Reset asserted in the 2nd WAIT cycle of an LW -> next cycle `dmem_req`=0, all `wb_*`=0; a following ADD completes normally.
- SW at 0x302 with the macro defined -> no `dmem_req`, `wb_misalign`=1, `wb_reg_write`=0. Without the macro -> `dmem_addr`=0x300, `dmem_wstrb`=1111.
